it_blk_ctrl: RTL and testbench

//  Sequences Thumb-2 IT blocks for the arm_core decode stage. Owns ITSTATE[7:0].

---
 rtl/arm_core_pkg.sv | 41 ++++
 rtl/cond_eval.sv | 42 ++++
 rtl/it_blk_ctrl.sv | 118 +++++++++++
 tb/tb_it_blk_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_core_pkg.sv
// Shared arm_core definitions: condition codes, APSR bit positions, IT opcode,
// and the IT-block sequencer state type.
package arm_core_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int unsigned APSR_N = 4;
  localparam int unsigned APSR_Z = 3;
  localparam int unsigned APSR_C = 2;
  localparam int unsigned APSR_V = 1;
  localparam int unsigned APSR_Q = 0;

  localparam logic [7:0] IT_OPC = 8'hBF;

  // IDLE: mask == 0, IN_BLK: mask != 0 (state is derived from ITSTATE, not stored)
  typedef enum logic {
    IT_IDLE   = 1'b0,
    IT_IN_BLK = 1'b1
  } it_state_e;

  // An IT with firstcond NV, or AL with more than one instruction, is unpredictable
  function automatic logic it_cond_illegal(input logic [3:0] firstcond, input logic [3:0] mask);
    return (firstcond == COND_NV) || ((firstcond == COND_AL) && (mask != 4'b1000));
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Condition-code evaluator: tests a 4-bit ARM condition against APSR flags.
// Purely combinational so conditional branches can share it.
module cond_eval
  import arm_core_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [4:0] i_apsr,
  output logic       o_pass
);

  logic w_n, w_z, w_c, w_v;
  logic w_unused_q;

  assign w_n        = i_apsr[APSR_N];
  assign w_z        = i_apsr[APSR_Z];
  assign w_c        = i_apsr[APSR_C];
  assign w_v        = i_apsr[APSR_V];
  assign w_unused_q = i_apsr[APSR_Q];

  // Decode the condition into a pass/fail; AL and NV both execute
  always_comb begin
    o_pass = 1'b1;
    case (i_cond)
      COND_EQ: o_pass = w_z;
      COND_NE: o_pass = ~w_z;
      COND_CS: o_pass = w_c;
      COND_CC: o_pass = ~w_c;
      COND_MI: o_pass = w_n;
      COND_PL: o_pass = ~w_n;
      COND_VS: o_pass = w_v;
      COND_VC: o_pass = ~w_v;
      COND_HI: o_pass = w_c & ~w_z;
      COND_LS: o_pass = ~w_c | w_z;
      COND_GE: o_pass = (w_n == w_v);
      COND_LT: o_pass = (w_n != w_v);
      COND_GT: o_pass = ~w_z & (w_n == w_v);
      COND_LE: o_pass = w_z | (w_n != w_v);
      default: o_pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/it_blk_ctrl.sv
// Thumb-2 IT block sequencer. Owns ITSTATE, loads it on an IT instruction,
// advances it per accepted instruction and qualifies each one as execute/skip.
//
//   state  | meaning
//   IDLE   | ITSTATE mask == 0, instructions execute unconditionally
//   IN_BLK | ITSTATE mask != 0, current instruction is conditional on cur_cond
module it_blk_ctrl
  import arm_core_pkg::*;
#(
  parameter bit IT_CHECK_EN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_inst_valid,
  input  logic        i_inst_ack,
  input  logic [31:0] i_inst,
  input  logic        i_is_32bit,
  input  logic [4:0]  i_apsr,
  input  logic        i_flush,
  input  logic        i_it_restore,
  input  logic [7:0]  i_it_restore_data,
  output logic [7:0]  o_itstate,
  output logic        o_in_it_blk,
  output logic [3:0]  o_cur_cond,
  output logic        o_hint_or_exc,
  output logic        o_it_last,
  output logic        o_it_err
);

  logic [7:0] r_itstate;
  logic       r_it_err;

  logic [7:0] w_itstate_nxt;
  logic       w_it_err_nxt;
  it_state_e  w_state;
  logic       w_accept;
  logic       w_it_detect;
  logic       w_it_illegal;
  logic [7:0] w_itstate_adv;
  logic       w_in_blk;
  logic [3:0] w_cur_cond;
  logic       w_last;
  logic       w_hint;
  logic       w_pass;
  logic       w_unused_inst;

  assign w_accept      = i_inst_valid & i_inst_ack;
  assign w_it_detect   = ~i_is_32bit & (i_inst[31:24] == IT_OPC) & (i_inst[19:16] != 4'h0);
  assign w_it_illegal  = it_cond_illegal(i_inst[23:20], i_inst[19:16]);
  assign w_state       = (r_itstate[3:0] != 4'h0) ? IT_IN_BLK : IT_IDLE;
  assign w_unused_inst = ^i_inst[15:0];

  // Shift the condition LSB and mask left; the top three condition bits stay put
  assign w_itstate_adv = (r_itstate[2:0] == 3'b000) ? 8'h00
                                                    : {r_itstate[7:5], r_itstate[3:0], 1'b0};

  // State register: ITSTATE and the registered illegal-IT pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_itstate <= 8'h00;
      r_it_err  <= 1'b0;
    end else begin
      r_itstate <= w_itstate_nxt;
      r_it_err  <= w_it_err_nxt;
    end
  end

  // Next-state: flush beats restore beats the accept-driven load/advance
  always_comb begin
    w_itstate_nxt = r_itstate;
    w_it_err_nxt  = 1'b0;
    if (i_flush) begin
      w_itstate_nxt = 8'h00;
    end else if (i_it_restore) begin
      w_itstate_nxt = i_it_restore_data;
    end else if (w_accept) begin
      case (w_state)
        IT_IDLE: begin
          if (w_it_detect) begin
            if (IT_CHECK_EN && w_it_illegal) begin
              w_it_err_nxt = 1'b1;
            end else begin
              w_itstate_nxt = i_inst[23:16];
            end
          end
        end
        IT_IN_BLK: begin
          // A nested IT is never loaded; it just consumes a slot in the block
          w_it_err_nxt  = IT_CHECK_EN & w_it_detect;
          w_itstate_nxt = w_itstate_adv;
        end
        default: w_itstate_nxt = 8'h00;
      endcase
    end
  end

  // Outputs: zero-latency decode of the current ITSTATE
  always_comb begin
    w_in_blk   = (w_state == IT_IN_BLK);
    w_cur_cond = w_in_blk ? r_itstate[7:4] : COND_AL;
    w_last     = w_in_blk & (r_itstate[2:0] == 3'b000);
    w_hint     = i_inst_valid & w_pass;
  end

  cond_eval u_cond_eval (
    .i_cond (w_cur_cond),
    .i_apsr (i_apsr),
    .o_pass (w_pass)
  );

  assign o_itstate     = r_itstate;
  assign o_in_it_blk   = w_in_blk;
  assign o_cur_cond    = w_cur_cond;
  assign o_it_last     = w_last;
  assign o_hint_or_exc = w_hint;
  assign o_it_err      = r_it_err;

endmodule

// File: tb/tb_it_blk_ctrl.sv
// Testbench for it_blk_ctrl: directed IT scenarios plus randomized traffic,
// checked by a queue-based model of the pending conditions in the IT block.
module tb_it_blk_ctrl;

  logic        clk;
  logic        rst;
  logic        inst_valid;
  logic        inst_ack;
  logic [31:0] inst;
  logic        is_32bit;
  logic [4:0]  apsr;
  logic        flush;
  logic        it_restore;
  logic [7:0]  it_restore_data;
  logic [7:0]  itstate;
  logic        in_it_blk;
  logic [3:0]  cur_cond;
  logic        hint_or_exc;
  logic        it_last;
  logic        it_err;

  it_blk_ctrl #(.IT_CHECK_EN(1'b1)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_inst_valid      (inst_valid),
    .i_inst_ack        (inst_ack),
    .i_inst            (inst),
    .i_is_32bit        (is_32bit),
    .i_apsr            (apsr),
    .i_flush           (flush),
    .i_it_restore      (it_restore),
    .i_it_restore_data (it_restore_data),
    .o_itstate         (itstate),
    .o_in_it_blk       (in_it_blk),
    .o_cur_cond        (cur_cond),
    .o_hint_or_exc     (hint_or_exc),
    .o_it_last         (it_last),
    .o_it_err          (it_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       hint;
    logic       inblk;
    logic       last;
    logic       err;
    logic [3:0] cur;
    logic [7:0] its;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] mq[$];      // conditions still to be applied, current one first
  logic       err_pend;
  int         checks;
  int         errors;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic cond_ok(input logic [3:0] c, input logic [4:0] a);
    logic n, z, cf, v;
    n = a[4]; z = a[3]; cf = a[2]; v = a[1];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cf && !z;
      4'h9: return !cf || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  // Expand an IT firstcond/mask byte into the list of per-instruction conditions
  task automatic model_load(input logic [7:0] val);
    logic [3:0] fc;
    logic [3:0] m;
    int p;
    mq.delete();
    fc = val[7:4];
    m  = val[3:0];
    if (m == 4'h0) return;
    p = 0;
    while (m[p] == 1'b0) p++;
    mq.push_back(fc);
    for (int k = 1; k < 4 - p; k++) mq.push_back({fc[3:1], m[4-k]});
  endtask

  // Architectural ITSTATE view of the pending list: then/else bits followed by a stop bit
  function automatic logic [7:0] model_its();
    logic [3:0] m;
    if (mq.size() == 0) return 8'h00;
    m = 4'h0;
    for (int k = 1; k < mq.size(); k++) m[4-k] = mq[k][0];
    m[4-mq.size()] = 1'b1;
    return {mq[0], m};
  endfunction

  task automatic cyc(input logic v, input logic ack, input logic [31:0] ins, input logic i32,
                     input logic [4:0] a, input logic fl, input logic rs,
                     input logic rest, input logic [7:0] rdata);
    exp_t e;
    logic det, bad, new_err;
    @(posedge clk);
    #1;
    inst_valid = v; inst_ack = ack; inst = ins; is_32bit = i32; apsr = a;
    flush = fl; rst = rs; it_restore = rest; it_restore_data = rdata;
    e.inblk = (mq.size() != 0);
    e.cur   = e.inblk ? mq[0] : 4'hE;
    e.last  = (mq.size() == 1);
    e.hint  = v && cond_ok(e.cur, a);
    e.err   = err_pend;
    e.its   = model_its();
    exp_q.push_back(e);
    det = !i32 && (ins[31:24] == 8'hBF) && (ins[19:16] != 4'h0);
    bad = (ins[23:20] == 4'hF) || ((ins[23:20] == 4'hE) && (ins[19:16] != 4'h8));
    new_err = 1'b0;
    if (rs) begin
      mq.delete();
    end else if (fl) begin
      mq.delete();
    end else if (rest) begin
      model_load(rdata);
    end else if (v && ack) begin
      if (mq.size() != 0) begin
        if (det) new_err = 1'b1;
        void'(mq.pop_front());
      end else if (det) begin
        if (bad) new_err = 1'b1;
        else model_load(ins[23:16]);
      end
    end
    err_pend = rs ? 1'b0 : new_err;
  endtask

  task automatic op(input logic [31:0] ins, input logic [4:0] a);
    cyc(1'b1, 1'b1, ins, 1'b0, a, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0000_0000, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("itstate",   {24'h0, itstate},     {24'h0, e.its});
      chk("in_it_blk", {31'h0, in_it_blk},   {31'h0, e.inblk});
      chk("cur_cond",  {28'h0, cur_cond},    {28'h0, e.cur});
      chk("hint",      {31'h0, hint_or_exc}, {31'h0, e.hint});
      chk("it_last",   {31'h0, it_last},     {31'h0, e.last});
      chk("it_err",    {31'h0, it_err},      {31'h0, e.err});
    end
  end

  localparam logic [31:0] NOP16 = 32'h4600_1234;

  initial begin
    logic [7:0] t1_its [4];
    checks = 0; errors = 0; err_pend = 1'b0;
    rst = 1'b1; inst_valid = 1'b0; inst_ack = 1'b0; inst = 32'h0; is_32bit = 1'b0;
    apsr = 5'b0; flush = 1'b0; it_restore = 1'b0; it_restore_data = 8'h0;
    repeat (2) @(posedge clk);

    // 1: ITTE EQ with Z set; itstate walks 06,0C,18,00
    t1_its = '{8'h06, 8'h0C, 8'h18, 8'h00};
    op(32'hBF06_0000, 5'b01000);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) op(NOP16, 5'b01000);
      else idle();
      @(negedge clk);
      chk("t1_itstate", {24'h0, itstate}, {24'h0, t1_its[i]});
    end

    // 2: ITNE, single instruction
    op(32'hBF18_0000, 5'b00000);
    op(NOP16, 5'b00000);
    idle();

    // 3: ITTT EQ held in a stall while Z toggles
    op(32'hBF02_0000, 5'b00000);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b0, NOP16, 1'b0, (i % 2 == 0) ? 5'b01000 : 5'b00000, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("t3_stall_its", {24'h0, itstate}, 32'h02);
    op(NOP16, 5'b01000);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 5'b0, 1'b1, 1'b0, 1'b0, 8'h00);

    // 4: ITTT GE, one accept, then flush; next inst unconditional with N!=V
    op(32'hBFA2_0000, 5'b00000);
    op(NOP16, 5'b00000);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 5'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    op(NOP16, 5'b10000);

    // 5: nested IT inside a block, and an IT with firstcond NV
    op(32'hBF04_0000, 5'b01000);
    op(32'hBF06_0000, 5'b01000);
    op(NOP16, 5'b01000);
    op(NOP16, 5'b01000);
    op(32'hBFF8_0000, 5'b00000);
    idle();
    @(negedge clk);
    chk("t5_nv_not_loaded", {24'h0, itstate}, 32'h00);

    // 6: restore loses to flush, then restore alone
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 5'b0, 1'b1, 1'b0, 1'b1, 8'h0C);
    idle();
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 5'b0, 1'b0, 1'b0, 1'b1, 8'h0C);
    idle();
    @(negedge clk);
    chk("t6_restore_its", {24'h0, itstate}, 32'h0C);
    chk("t6_cur_cond", {28'h0, cur_cond}, 32'h0);
    op(NOP16, 5'b00000);
    op(NOP16, 5'b00000);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] ins;
      logic [7:0]  rd;
      ins = $urandom();
      if ($urandom_range(0, 9) < 4) ins[31:24] = 8'hBF;
      rd = $urandom();
      if (rd[3:0] == 4'h0) rd[3:0] = 4'h8;
      cyc($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, ins,
          $urandom_range(0, 9) < 2, 5'($urandom()),
          $urandom_range(0, 49) == 0, $urandom_range(0, 199) == 0,
          $urandom_range(0, 49) == 0, rd);
    end

    idle();
    idle();
    @(negedge clk);
    #1;
    chk("drain", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
